// File: rtl/CPU_Param.sv
// Shared CPU constants: one-hot instruction-type bit positions and the reset PC.
package CPU_Param;

   localparam int INSTR_W = 60;

   localparam int I_SLL = 0;
   localparam int I_LB  = 12;
   localparam int I_LBU = 13;
   localparam int I_LH  = 14;
   localparam int I_LHU = 15;
   localparam int I_LW  = 16;
   localparam int I_SB  = 17;
   localparam int I_SH  = 18;
   localparam int I_SW  = 19;

   localparam logic [31:0]        RESET_PC = 32'h0000_3000;
   localparam logic [INSTR_W-1:0] SLL_CODE = INSTR_W'(1) << I_SLL;

   function automatic logic [INSTR_W-1:0] instrCode(input int pos);
      return INSTR_W'(1) << pos;
   endfunction

endpackage

// File: rtl/dm.sv
// Data memory: word array with per-byte write enables, combinational read and synchronous clear.
module dm #(
   parameter int WORDS = 1024,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [WORDS];

   // Clear has priority, so a store sitting in Mem during reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS-style Mem pipeline stage: WB->Mem store-data forwarding, DM access, load extension, Mem/WB register.
// Define MEM_SUBWORD_EN to enable sb/sh/lb/lbu/lh/lhu; otherwise they act as non-memory instructions.
module mem_stage
   import CPU_Param::*;
#(
   parameter int DM_WORDS = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        PC_EX_to_Mem,
   input  logic [4:0]         Rt_EX_to_Mem,
   input  logic [4:0]         RegWriteAddr_EX_to_Mem,
   input  logic [INSTR_W-1:0] InstrType_EX_to_Mem,
   input  logic [31:0]        ALUOut_EX_to_Mem,
   input  logic [31:0]        DMWriteData_EX_to_Mem,
   input  logic [4:0]         RegWriteAddr_WB,
   input  logic [31:0]        RegWriteData_WB,
   output logic [31:0]        PC_Mem_to_WB,
   output logic [4:0]         RegWriteAddr_Mem_to_WB,
   output logic [INSTR_W-1:0] InstrType_Mem_to_WB,
   output logic [31:0]        ALUOut_Mem_to_WB,
   output logic [31:0]        DMReadData_Mem_to_WB
);

   localparam int AW = $clog2(DM_WORDS);

   logic [31:0]        storeData;
   logic [31:0]        wordWrite;
   logic [3:0]         byteEn;
   logic [31:0]        rdWord;
   logic [AW-1:0]      wordIdx;

   logic [31:0]        pc_d,     pc_q;
   logic [4:0]         wa_d,     wa_q;
   logic [INSTR_W-1:0] itype_d,  itype_q;
   logic [31:0]        alu_d,    alu_q;
   logic [31:0]        rdata_d,  rdata_q;

   assign storeData = (RegWriteAddr_WB != 5'd0 && RegWriteAddr_WB == Rt_EX_to_Mem)
                      ? RegWriteData_WB : DMWriteData_EX_to_Mem;
   assign wordIdx   = ALUOut_EX_to_Mem[AW+1:2];

   dm #(
      .WORDS(DM_WORDS),
      .AW   (AW)
   ) u_dm (
      .clk    (clk),
      .reset  (reset),
      .addr_i (wordIdx),
      .be_i   (byteEn),
      .wdata_i(wordWrite),
      .rdata_o(rdWord)
   );

   // Sub-word stores replicate the data across lanes and let byteEn pick the lane.
   always_comb begin
      byteEn    = 4'b0000;
      wordWrite = storeData;
      if (InstrType_EX_to_Mem[I_SW]) begin
         byteEn = 4'b1111;
      end
`ifdef MEM_SUBWORD_EN
      else if (InstrType_EX_to_Mem[I_SB]) begin
         byteEn    = 4'b0001 << ALUOut_EX_to_Mem[1:0];
         wordWrite = {4{storeData[7:0]}};
      end else if (InstrType_EX_to_Mem[I_SH]) begin
         byteEn    = ALUOut_EX_to_Mem[1] ? 4'b1100 : 4'b0011;
         wordWrite = {2{storeData[15:0]}};
      end
`endif
   end

`ifdef MEM_SUBWORD_EN
   logic [7:0]  selByte;
   logic [15:0] selHalf;

   always_comb begin
      selByte = rdWord[7:0];
      case (ALUOut_EX_to_Mem[1:0])
         2'd1:    selByte = rdWord[15:8];
         2'd2:    selByte = rdWord[23:16];
         2'd3:    selByte = rdWord[31:24];
         default: selByte = rdWord[7:0];
      endcase
      selHalf = ALUOut_EX_to_Mem[1] ? rdWord[31:16] : rdWord[15:0];
   end
`endif

   always_comb begin
      pc_d    = PC_EX_to_Mem;
      wa_d    = RegWriteAddr_EX_to_Mem;
      itype_d = InstrType_EX_to_Mem;
      alu_d   = ALUOut_EX_to_Mem;
      rdata_d = 32'd0;
      if (InstrType_EX_to_Mem[I_LW]) begin
         rdata_d = rdWord;
      end
`ifdef MEM_SUBWORD_EN
      else if (InstrType_EX_to_Mem[I_LB]) begin
         rdata_d = {{24{selByte[7]}}, selByte};
      end else if (InstrType_EX_to_Mem[I_LBU]) begin
         rdata_d = {24'd0, selByte};
      end else if (InstrType_EX_to_Mem[I_LH]) begin
         rdata_d = {{16{selHalf[15]}}, selHalf};
      end else if (InstrType_EX_to_Mem[I_LHU]) begin
         rdata_d = {16'd0, selHalf};
      end
`endif
   end

   // Mem/WB register has no stall or flush; reset parks it on an sll at the boot PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         wa_q    <= '0;
         itype_q <= SLL_CODE;
         alu_q   <= '0;
         rdata_q <= '0;
      end else begin
         pc_q    <= pc_d;
         wa_q    <= wa_d;
         itype_q <= itype_d;
         alu_q   <= alu_d;
         rdata_q <= rdata_d;
      end
   end

   assign PC_Mem_to_WB           = pc_q;
   assign RegWriteAddr_Mem_to_WB = wa_q;
   assign InstrType_Mem_to_WB    = itype_q;
   assign ALUOut_Mem_to_WB       = alu_q;
   assign DMReadData_Mem_to_WB   = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-addressed reference memory, directed cases then random traffic.
module tb_mem_stage;
   import CPU_Param::*;

   localparam int DM_WORDS = 1024;
   localparam int DM_BYTES = DM_WORDS * 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [31:0]        pcIn;
   logic [4:0]         rtIn;
   logic [4:0]         waIn;
   logic [INSTR_W-1:0] itypeIn;
   logic [31:0]        aluIn;
   logic [31:0]        rawIn;
   logic [4:0]         wbAddr;
   logic [31:0]        wbData;
   logic [31:0]        pcOut;
   logic [4:0]         waOut;
   logic [INSTR_W-1:0] itypeOut;
   logic [31:0]        aluOut;
   logic [31:0]        rdOut;

   typedef struct {
      logic [31:0]        pc;
      logic [4:0]         wa;
      logic [INSTR_W-1:0] itype;
      logic [31:0]        alu;
      logic [31:0]        rd;
   } exp_t;

   exp_t        expQ[$];
   exp_t        monExp;
   logic [7:0]  refMem [DM_BYTES];
   int          checks = 0;
   int          passes = 0;
   logic [31:0] pcCounter = 32'h0000_0100;

   always #5 clk = ~clk;

   mem_stage #(.DM_WORDS(DM_WORDS)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .PC_EX_to_Mem          (pcIn),
      .Rt_EX_to_Mem          (rtIn),
      .RegWriteAddr_EX_to_Mem(waIn),
      .InstrType_EX_to_Mem   (itypeIn),
      .ALUOut_EX_to_Mem      (aluIn),
      .DMWriteData_EX_to_Mem (rawIn),
      .RegWriteAddr_WB       (wbAddr),
      .RegWriteData_WB       (wbData),
      .PC_Mem_to_WB          (pcOut),
      .RegWriteAddr_Mem_to_WB(waOut),
      .InstrType_Mem_to_WB   (itypeOut),
      .ALUOut_Mem_to_WB      (aluOut),
      .DMReadData_Mem_to_WB  (rdOut)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Drives one instruction into Mem and predicts what WB sees after the next edge.
   task automatic applyStimulus(input bit rst, input int pos, input logic [31:0] alu,
                                input logic [31:0] raw, input logic [4:0] rt,
                                input logic [4:0] wbA, input logic [31:0] wbD);
      exp_t        e;
      logic [31:0] sdata;
      logic [15:0] h;
      int          a, w, hb;
      @(posedge clk);
      #2;
      reset   = rst;
      pcIn    = pcCounter;
      rtIn    = rt;
      waIn    = 5'($urandom_range(0, 31));
      itypeIn = instrCode(pos);
      aluIn   = alu;
      rawIn   = raw;
      wbAddr  = wbA;
      wbData  = wbD;
      pcCounter = pcCounter + 32'd4;
      e.pc = pcIn; e.wa = waIn; e.itype = itypeIn; e.alu = alu; e.rd = 32'd0;
      if (rst) begin
         e.pc = RESET_PC; e.wa = 5'd0; e.itype = instrCode(I_SLL); e.alu = 32'd0;
         for (int i = 0; i < DM_BYTES; i++) refMem[i] = 8'd0;
      end else begin
         sdata = (wbA != 5'd0 && wbA == rt) ? wbD : raw;
         a  = int'(alu % DM_BYTES);
         w  = a - (a % 4);
         hb = a - (a % 2);
         case (pos)
            I_LW: e.rd = {refMem[w+3], refMem[w+2], refMem[w+1], refMem[w]};
            I_SW: begin
               refMem[w]   = sdata[7:0];   refMem[w+1] = sdata[15:8];
               refMem[w+2] = sdata[23:16]; refMem[w+3] = sdata[31:24];
            end
`ifdef MEM_SUBWORD_EN
            I_LB:  e.rd = {{24{refMem[a][7]}}, refMem[a]};
            I_LBU: e.rd = {24'd0, refMem[a]};
            I_LH: begin
               h = {refMem[hb+1], refMem[hb]};
               e.rd = {{16{h[15]}}, h};
            end
            I_LHU: e.rd = {16'd0, refMem[hb+1], refMem[hb]};
            I_SB:  refMem[a] = sdata[7:0];
            I_SH: begin
               refMem[hb] = sdata[7:0]; refMem[hb+1] = sdata[15:8];
            end
`endif
            default: e.rd = 32'd0;
         endcase
      end
      expQ.push_back(e);
   endtask

   // Monitor: the Mem/WB register presents a result every edge once something was issued.
   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput("PC_Mem_to_WB",           64'(pcOut),    64'(monExp.pc));
         checkOutput("RegWriteAddr_Mem_to_WB", 64'(waOut),    64'(monExp.wa));
         checkOutput("InstrType_Mem_to_WB",    64'(itypeOut), 64'(monExp.itype));
         checkOutput("ALUOut_Mem_to_WB",       64'(aluOut),   64'(monExp.alu));
         checkOutput("DMReadData_Mem_to_WB",   64'(rdOut),    64'(monExp.rd));
      end
   end

   int randPos [11] = '{I_LW, I_SW, I_LB, I_LBU, I_LH, I_LHU, I_SB, I_SH, I_SLL, 7, 40};

   initial begin
      reset = 1'b1; pcIn = '0; rtIn = '0; waIn = '0; itypeIn = instrCode(I_SLL);
      aluIn = '0; rawIn = '0; wbAddr = '0; wbData = '0;

      // Stores during reset must be dropped; outputs park at the boot state.
      applyStimulus(1'b1, I_SW, 32'h10, 32'hDEADBEEF, 5'd1, 5'd0, 32'd0);
      applyStimulus(1'b1, I_SW, 32'h00, 32'h11112222, 5'd1, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LW, 32'h10, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LW, 32'h00, 32'd0, 5'd0, 5'd0, 32'd0);

      applyStimulus(1'b0, I_SW, 32'h10, 32'h12345678, 5'd3, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LW, 32'h10, 32'd0, 5'd0, 5'd0, 32'd0);

      applyStimulus(1'b0, I_SW, 32'h10, 32'h01010101, 5'd5, 5'd5, 32'hCAFEBABE);
      applyStimulus(1'b0, I_LW, 32'h10, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, I_SW, 32'h10, 32'h0BADF00D, 5'd5, 5'd0, 32'hCAFEBABE);
      applyStimulus(1'b0, I_LW, 32'h13, 32'd0, 5'd0, 5'd0, 32'd0);

      applyStimulus(1'b0, I_SW, 32'h0000_1000, 32'h55AA55AA, 5'd2, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LW, 32'h0, 32'd0, 5'd0, 5'd0, 32'd0);

      applyStimulus(1'b0, I_SW, 32'h0, 32'h0, 5'd2, 5'd0, 32'd0);
      applyStimulus(1'b0, I_SB, 32'h3, 32'h000000F0, 5'd2, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LW, 32'h0, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LB, 32'h3, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LBU, 32'h3, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, I_LH, 32'h2, 32'd0, 5'd0, 5'd0, 32'd0);
      applyStimulus(1'b0, 40, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b0, randPos[$urandom_range(0, 10)], $urandom() & 32'hFFFF_F03F,
                       $urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom());
      end

      applyStimulus(1'b1, I_SW, 32'h20, 32'h87654321, 5'd1, 5'd0, 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, I_LW, 32'(i * 4), 32'd0, 5'd0, 5'd0, 32'd0);
      end

      @(posedge clk);
      @(posedge clk);
      #3;
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, data memory depth in 32-bit words (power of two).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 PC_EX_to_Mem  input  32  PC of instruction in Mem.
REQ-005 Rt_EX_to_Mem  input  5  Rt index of instruction in Mem.
REQ-006 RegWriteAddr_EX_to_Mem  input  5  GPR write-back address.
REQ-007 InstrType_EX_to_Mem  input  60  one-hot instruction type.
REQ-008 ALUOut_EX_to_Mem  input  32  ALU result / effective byte address.
REQ-009 DMWriteData_EX_to_Mem  input  32  raw store data (Rt value).
REQ-010 RegWriteAddr_WB  input  5  GPR address being written by WB this cycle.
REQ-011 RegWriteData_WB  input  32  GPR data being written by WB this cycle.
REQ-012 PC_Mem_to_WB, RegWriteAddr_Mem_to_WB, InstrType_Mem_to_WB, ALUOut_Mem_to_WB  output  32/5/60/32  registered pass-through to WB.
REQ-013 DMReadData_Mem_to_WB  output  32  registered, extended load result.

Function
REQ-014 Store data SHALL be RegWriteData_WB when RegWriteAddr_WB != 0 and equals Rt_EX_to_Mem, else DMWriteData_EX_to_Mem.
REQ-015 Word index SHALL be ALUOut_EX_to_Mem[log2(DM_WORDS)+1:2]; upper address bits ignored (wrap modulo DM size).
REQ-016 sw SHALL write the full word at the rising edge ending its Mem cycle; low address bits [1:0] ignored.
REQ-017 Loads SHALL read the DM combinationally in Mem and register the result into DMReadData_Mem_to_WB on the same edge (one-cycle latency, visible in WB).
REQ-018 lw SHALL return the full word; [1:0] ignored.
REQ-019 A load in cycle N+1 after a store to the same word in cycle N SHALL return the stored value.
REQ-020 Non-memory instructions SHALL leave the DM unchanged; DMReadData_Mem_to_WB SHALL be 0 for them.
REQ-021 Pass-through outputs SHALL register their _EX_to_Mem counterparts every non-reset edge, no stall or flush.

Reset
REQ-022 Reset SHALL, on the edge: clear every DM word to 0; set PC_Mem_to_WB=32'h0000_3000, InstrType_Mem_to_WB=sll encoding, all other outputs 0.
REQ-023 A store present in Mem during a reset cycle SHALL NOT write the DM.

Configuration
REQ-024 Macro MEM_SUBWORD_EN defined: sb writes byte lane ALUOut[1:0] (lane 0 = bits 7:0), sh writes half ALUOut[1] (bit 0 ignored); lb/lh sign-extend, lbu/lhu zero-extend the selected lane; other lanes untouched.
REQ-025 Macro undefined: sb, sh, lb, lbu, lh, lhu SHALL behave as non-memory instructions (no write, read data 0).

Structure
REQ-026 One-hot bit positions for lw, sw, lb, lbu, lh, lhu, sb, sh, sll and the reset PC 32'h0000_3000 SHALL live in the shared CPU_Param package.
REQ-027 Sub-module dm (DM array, byte-enable write, synchronous clear) SHALL be instantiated; extension and forwarding logic stay in mem_stage.

Verification
REQ-028 sw ALUOut=0x10, data 0x12345678; next cycle lw 0x10 -> DMReadData_Mem_to_WB=0x12345678 one cycle later.
REQ-029 sw with Rt=5 while RegWriteAddr_WB=5, RegWriteData_WB=0xCAFEBABE -> DM word 4 holds 0xCAFEBABE; repeat with RegWriteAddr_WB=0 -> raw data stored.
REQ-030 (MEM_SUBWORD_EN) word 0=0x00000000; sb 0x3 data 0x000000F0 -> word 0x F0000000; lb 0x3 -> 0xFFFFFFF0; lbu 0x3 -> 0x000000F0; lh 0x2 -> 0xFFFFF000.
REQ-031 (no macro) sb 0x3 data 0xAB -> word 0 unchanged; lb -> 0.
REQ-032 sw ALUOut=0x00001000 with DM_WORDS=1024 -> word 0 written (wrap).
REQ-033 sw asserted in a reset cycle -> DM stays 0; outputs PC=0x3000, InstrType=sll, others 0.
